// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared font, blank pattern and scan state encoding for the seven-segment driver
package sevenseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0;

  localparam logic ST_BLANK_ENC = 1'b0;
  localparam logic ST_ON_ENC    = 1'b1;

  typedef enum logic {
    ST_BLANK = ST_BLANK_ENC,
    ST_ON    = ST_ON_ENC
  } seg_state_e;

  // Segments a..g on bits 6..0, active-high
  function automatic logic [6:0] SEG_FONT(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_tick_gen.sv
// rtl/sevenseg_tick_gen.sv - free-running slot prescaler with a tick on its wrap cycle
module sevenseg_tick_gen #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reset to the last count so the first edge after release is already a tick
  always_comb begin
    tick  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CNT_W'(REFRESH_DIV - 1);
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sevenseg_scan_driver.sv
// rtl/sevenseg_scan_driver.sv - multiplexed common-cathode display scanner with blanking, dp, enable and zero suppression
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_suppress,
  output logic [DIGITS-1:0]     grounds,
  output logic [6:0]            display,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);

  if (DIGITS < 2 || REFRESH_DIV < 4 || BLANK_CYC < 1 || BLANK_CYC > REFRESH_DIV - 2) begin : g_param_check
    $error("sevenseg_scan_driver: parameter out of range");
  end

  logic [CNT_W-1:0]    cnt;
  logic                tick;
  seg_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [DIGITS-1:0]   lit_q, lit_d, lit_calc;
  logic [DIGITS-1:0]   grounds_q, grounds_d, gnd_sel;
  logic [6:0]          display_q, display_d;
  logic                dp_q, dp_d, frame_done_q, frame_done_d;
  logic [3:0]          nib;
  logic                sel_lit, sel_dp, run, sup;

  sevenseg_tick_gen #(.REFRESH_DIV(REFRESH_DIV), .CNT_W(CNT_W)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .cnt  (cnt),
    .tick (tick)
  );

  // Lit mask from the values about to be captured; disabled digits do not break the zero run
  always_comb begin
    lit_calc = '0;
    run      = 1'b1;
    sup      = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      sup = lz_suppress && run && (data_in[4*(DIGITS-1-i) +: 4] == 4'h0) &&
            !dp_in[DIGITS-1-i] && (i != DIGITS - 1);
      if (digit_en[DIGITS-1-i]) begin
        run                  = sup;
        lit_calc[DIGITS-1-i] = !sup;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    dp_sh_d      = dp_sh_q;
    lit_d        = lit_q;
    frame_done_d = 1'b0;
    grounds_d    = '1;
    display_d    = SEG_OFF;
    dp_d         = 1'b0;
    nib          = 4'h0;
    sel_lit      = 1'b0;
    sel_dp       = 1'b0;
    gnd_sel      = '1;

    if (tick) begin
      state_d = ST_BLANK;
      idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      if (idx_d == '0) begin
        data_d       = data_in;
        dp_sh_d      = dp_in;
        lit_d        = lit_calc;
        frame_done_d = 1'b1;
      end
    end else if (state_q == ST_BLANK && cnt == CNT_W'(BLANK_CYC - 1)) begin
      state_d = ST_ON;
    end

    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib                 = data_q[4*(DIGITS-1-i) +: 4];
        sel_lit             = lit_q[DIGITS-1-i];
        sel_dp              = dp_sh_q[DIGITS-1-i];
        gnd_sel[DIGITS-1-i] = 1'b0;
      end
    end

    // Capture and ON entry never share an edge, so shadow state is stable here
    if (state_d == ST_ON && sel_lit) begin
      grounds_d = gnd_sel;
      display_d = SEG_FONT(nib);
      dp_d      = sel_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ON;
      idx_q        <= IDX_W'(DIGITS - 1);
      data_q       <= '0;
      dp_sh_q      <= '0;
      lit_q        <= '0;
      grounds_q    <= '1;
      display_q    <= SEG_OFF;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      dp_sh_q      <= dp_sh_d;
      lit_q        <= lit_d;
      grounds_q    <= grounds_d;
      display_q    <= display_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign grounds    = grounds_q;
  assign display    = display_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb/tb_sevenseg_scan_driver.sv - directed self-checking bench for sevenseg_scan_driver
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_suppress;
  logic [3:0]  grounds;
  logic [6:0]  display;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  sevenseg_scan_driver #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_suppress(lz_suppress),
    .grounds    (grounds),
    .display    (display),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [12:0] obs, input logic [12:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge whose next posedge is the tick into digit 0
  task automatic check_frame(input string tag, input logic [15:0] eg, input logic [27:0] ed,
                             input logic [3:0] edp, input int chg_slot, input logic [15:0] chg_data);
    logic [12:0] exp_v;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        if (s == chg_slot && c == 3) data_in = chg_data;
        @(posedge clk);
        @(negedge clk);
        if (c < 2) exp_v = {(s == 0 && c == 0), 4'hF, 7'h00, 1'b0};
        else       exp_v = {1'b0, eg[15-4*s -: 4], ed[27-7*s -: 7], edp[3-s]};
        check_vec($sformatf("%s slot%0d cyc%0d", tag, s, c), {frame_done, grounds, display, dp}, exp_v);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; data_in = 16'h12AF; dp_in = 4'b0000; digit_en = 4'hF; lz_suppress = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_vec("reset_state", {frame_done, grounds, display, dp}, {1'b0, 4'hF, 7'h00, 1'b0});
    rst_n = 1'b1;

    check_frame("hex_12AF", 16'h7BDE, {7'h30, 7'h6D, 7'h77, 7'h47}, 4'b0000, -1, 16'h0);

    lz_suppress = 1'b1; data_in = 16'h0050;
    check_frame("lz_0050", 16'hFFDE, {7'h00, 7'h00, 7'h5B, 7'h7E}, 4'b0000, -1, 16'h0);

    data_in = 16'h0000;
    check_frame("lz_0000", 16'hFFFE, {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b0000, -1, 16'h0);

    data_in = 16'h0007; dp_in = 4'b0100;
    check_frame("lz_dp_0007", 16'hFBDE, {7'h00, 7'h7E, 7'h7E, 7'h70}, 4'b0100, -1, 16'h0);

    lz_suppress = 1'b0; data_in = 16'h12AF; dp_in = 4'b0000; digit_en = 4'b1010;
    check_frame("en_1010", 16'h7FDF, {7'h30, 7'h00, 7'h77, 7'h00}, 4'b0000, -1, 16'h0);

    lz_suppress = 1'b1; data_in = 16'h0005; digit_en = 4'b1011;
    check_frame("lz_transparent", 16'hFFFE, {7'h00, 7'h00, 7'h00, 7'h5B}, 4'b0000, -1, 16'h0);

    data_in = 16'h0000; digit_en = 4'b1110;
    check_frame("lz_last_disabled", 16'hFFFF, 28'h0, 4'b0000, -1, 16'h0);

    lz_suppress = 1'b0; data_in = 16'h1111; digit_en = 4'hF;
    check_frame("data_1111", 16'h7BDE, {4{7'h30}}, 4'b0000, -1, 16'h0);
    check_frame("midframe_chg", 16'h7BDE, {4{7'h30}}, 4'b0000, 1, 16'h2222);
    check_frame("data_2222", 16'h7BDE, {4{7'h6D}}, 4'b0000, -1, 16'h0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check_vec("pre_reset_on", {frame_done, grounds, display, dp}, {1'b0, 4'h7, 7'h6D, 1'b0});
    #2 rst_n = 1'b0;
    #1 check_vec("async_reset", {frame_done, grounds, display, dp}, {1'b0, 4'hF, 7'h00, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("after_reset", 16'h7BDE, {4{7'h6D}}, 4'b0000, -1, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
